// File: rtl/multi_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module      : multi_pwm_gen
// Description : NUM_CH independent cycle-programmed PWM channels with shadowed
//               reconfiguration, finite bursts and a global phase-align sync.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_pwm_gen #(
    parameter int  NUM_CH  = 4,
    parameter int  CNT_W   = 32,
    parameter int  BURST_W = 16,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic [CNT_W-1:0]   cfg_high,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic [NUM_CH-1:0]  enable,
    input  logic               sync,
    output logic [NUM_CH-1:0]  out,
    output logic [NUM_CH-1:0]  busy,
    output logic [NUM_CH-1:0]  done
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t             r_state;
        logic [CNT_W-1:0]   r_pend_p;
        logic [CNT_W-1:0]   r_pend_h;
        logic [BURST_W-1:0] r_pend_n;
        logic [CNT_W-1:0]   r_act_p;
        logic [CNT_W-1:0]   r_act_h;
        logic [BURST_W-1:0] r_act_n;
        logic [CNT_W-1:0]   r_cnt;
        logic [BURST_W-1:0] r_pulses;
        logic               r_out;
        logic               r_busy;
        logic               r_done;

        logic               w_sel;
        logic               w_start;
        logic               w_wrap;
        logic               w_burst_end;
        logic [CNT_W-1:0]   w_cnt_nxt;
        logic [BURST_W-1:0] w_pulses_nxt;

        assign w_sel        = cfg_we && (cfg_ch == CH_W'(c));
        // sync restarts a running channel; otherwise only an idle one starts
        assign w_start      = enable[c] && (sync || (r_state == S_IDLE));
        assign w_cnt_nxt    = r_cnt + 1'b1;
        assign w_pulses_nxt = r_pulses + 1'b1;
        assign w_wrap       = (r_cnt == (r_act_p - 1'b1));
        assign w_burst_end  = (r_act_n != '0) && (w_pulses_nxt == r_act_n);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state  <= S_IDLE;
                r_pend_p <= '0;
                r_pend_h <= '0;
                r_pend_n <= '0;
                r_act_p  <= '0;
                r_act_h  <= '0;
                r_act_n  <= '0;
                r_cnt    <= '0;
                r_pulses <= '0;
                r_out    <= 1'b0;
                r_busy   <= 1'b0;
                r_done   <= 1'b0;
            end else begin
                r_done <= 1'b0;

                // Loads below read the pre-write pending values (NBA ordering)
                if (w_sel) begin
                    r_pend_p <= cfg_period;
                    r_pend_h <= cfg_high;
                    r_pend_n <= cfg_burst;
                end

                if (!enable[c]) begin
                    r_state  <= S_IDLE;
                    r_cnt    <= '0;
                    r_pulses <= '0;
                    r_out    <= 1'b0;
                    r_busy   <= 1'b0;
                end else if (w_start) begin
                    r_act_p  <= r_pend_p;
                    r_act_h  <= r_pend_h;
                    r_act_n  <= r_pend_n;
                    r_cnt    <= '0;
                    r_pulses <= '0;
                    if (r_pend_p != '0) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_out   <= (r_pend_h != '0);
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_out   <= 1'b0;
                    end
                end else if (!w_wrap) begin
                    r_cnt <= w_cnt_nxt;
                    r_out <= (w_cnt_nxt < r_act_h);
                end else begin
                    r_pulses <= w_pulses_nxt;
                    r_cnt    <= '0;
                    if (w_burst_end) begin
                        r_state <= S_IDLE;
                        r_out   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_act_p <= r_pend_p;
                        r_act_h <= r_pend_h;
                        r_act_n <= r_pend_n;
                        if (r_pend_p != '0) begin
                            r_out <= (r_pend_h != '0);
                        end else begin
                            r_state <= S_IDLE;
                            r_out   <= 1'b0;
                            r_busy  <= 1'b0;
                        end
                    end
                end
            end
        end

        assign out[c]  = r_out;
        assign busy[c] = r_busy;
        assign done[c] = r_done;
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_pwm_gen
// Description : Directed self-checking bench for multi_pwm_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_pwm_gen;

    localparam int NUM_CH  = 4;
    localparam int CNT_W   = 32;
    localparam int BURST_W = 16;
    localparam int CH_W    = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_we;
    logic [CH_W-1:0]    cfg_ch;
    logic [CNT_W-1:0]   cfg_period;
    logic [CNT_W-1:0]   cfg_high;
    logic [BURST_W-1:0] cfg_burst;
    logic [NUM_CH-1:0]  enable;
    logic               sync;
    logic [NUM_CH-1:0]  out;
    logic [NUM_CH-1:0]  busy;
    logic [NUM_CH-1:0]  done;

    int checks = 0;
    int errors = 0;

    multi_pwm_gen #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .BURST_W(BURST_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_period(cfg_period),
        .cfg_high  (cfg_high),
        .cfg_burst (cfg_burst),
        .enable    (enable),
        .sync      (sync),
        .out       (out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // One clock edge; sample 1 ns later; single-cycle strobes drop afterwards
    task automatic tick;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        sync   = 1'b0;
    endtask

    task automatic set_cfg(input int ch, input int p, input int h, input int n);
        cfg_we     = 1'b1;
        cfg_ch     = CH_W'(ch);
        cfg_period = CNT_W'(p);
        cfg_high   = CNT_W'(h);
        cfg_burst  = BURST_W'(n);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        checks++;
        if ({out, busy, done} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got out=%b busy=%b done=%b expected all 0", out, busy, done);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle got busy=%b expected 0000", busy);
        end
    endtask

    task automatic test_continuous;
        set_cfg(0, 10, 3, 0);
        tick();
        enable[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if (out[0] !== ((k % 10) < 3) || busy[0] !== 1'b1 || done[0] !== 1'b0) begin
                errors++;
                $display("FAIL cont k=%0d got out=%b busy=%b done=%b expected out=%b busy=1 done=0",
                         k, out[0], busy[0], done[0], ((k % 10) < 3));
            end
        end
    endtask

    // Periods: 10/3 (write mid-period), 6/5, 6/5 (write on wrap edge), 10/3
    task automatic test_reconfig;
        int per [4] = '{10, 6, 6, 10};
        int hi  [4] = '{3, 5, 5, 3};
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < per[p]; k++) begin
                if (p == 0 && k == 4) set_cfg(0, 6, 5, 0);
                if (p == 2 && k == 0) set_cfg(0, 10, 3, 0);
                tick();
                checks++;
                if (out[0] !== (k < hi[p])) begin
                    errors++;
                    $display("FAIL reconfig period=%0d k=%0d got out=%b expected %b",
                             p, k, out[0], (k < hi[p]));
                end
            end
        end
        enable[0] = 1'b0;
        tick();
        checks++;
        if (out[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL reconfig_stop got out=%b busy=%b expected 0 0", out[0], busy[0]);
        end
    endtask

    task automatic test_burst;
        set_cfg(1, 4, 2, 3);
        tick();
        enable[1] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            checks++;
            if (out[1] !== ((k % 4) < 2) || busy[1] !== 1'b1 || done[1] !== 1'b0) begin
                errors++;
                $display("FAIL burst k=%0d got out=%b busy=%b done=%b expected out=%b busy=1 done=0",
                         k, out[1], busy[1], done[1], ((k % 4) < 2));
            end
        end
        tick();
        checks++;
        if (out[1] !== 1'b0 || busy[1] !== 1'b0 || done[1] !== 1'b1) begin
            errors++;
            $display("FAIL burst_end got out=%b busy=%b done=%b expected 0 0 1", out[1], busy[1], done[1]);
        end
        tick();
        checks++;
        if (out[1] !== 1'b1 || busy[1] !== 1'b1 || done[1] !== 1'b0) begin
            errors++;
            $display("FAIL burst_restart got out=%b busy=%b done=%b expected 1 1 0", out[1], busy[1], done[1]);
        end
        for (int k = 1; k < 6; k++) begin
            tick();
            checks++;
            if (out[1] !== ((k % 4) < 2)) begin
                errors++;
                $display("FAIL burst2 k=%0d got out=%b expected %b", k, out[1], ((k % 4) < 2));
            end
        end
        enable[1] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (out[1] !== 1'b0 || busy[1] !== 1'b0 || done[1] !== 1'b0) begin
                errors++;
                $display("FAIL abort k=%0d got out=%b busy=%b done=%b expected 0 0 0",
                         k, out[1], busy[1], done[1]);
            end
        end
    endtask

    task automatic test_edges;
        int   per  [4] = '{8, 8, 1, 0};
        int   hi   [4] = '{0, 12, 1, 5};
        logic eout [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic ebusy[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int t = 0; t < 4; t++) begin
            enable[2] = 1'b0;
            set_cfg(2, per[t], hi[t], 0);
            tick();
            enable[2] = 1'b1;
            for (int k = 0; k < 10; k++) begin
                tick();
                checks++;
                if (out[2] !== eout[t] || busy[2] !== ebusy[t]) begin
                    errors++;
                    $display("FAIL edge P=%0d H=%0d k=%0d got out=%b busy=%b expected out=%b busy=%b",
                             per[t], hi[t], k, out[2], busy[2], eout[t], ebusy[t]);
                end
            end
        end
        enable[2] = 1'b0;
        tick();
    endtask

    task automatic test_sync;
        set_cfg(0, 5, 2, 0);
        tick();
        enable[0] = 1'b1;
        tick();
        tick();
        set_cfg(3, 5, 2, 0);
        tick();
        enable[3] = 1'b1;
        tick();
        for (int k = 0; k < 12; k++) begin
            if (k == 0) sync = 1'b1;
            tick();
            checks++;
            if (out[0] !== ((k % 5) < 2) || out[3] !== ((k % 5) < 2)) begin
                errors++;
                $display("FAIL sync_align k=%0d got out0=%b out3=%b expected both %b",
                         k, out[0], out[3], ((k % 5) < 2));
            end
        end
        enable[3] = 1'b0;
        set_cfg(3, 5, 2, 2);
        tick();
        enable[3] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (out[3] !== ((k % 5) < 2) || done[3] !== 1'b0) begin
                errors++;
                $display("FAIL sync_burst k=%0d got out=%b done=%b expected out=%b done=0",
                         k, out[3], done[3], ((k % 5) < 2));
            end
        end
        sync = 1'b1;
        tick();
        checks++;
        if (done[3] !== 1'b0 || out[3] !== 1'b1 || busy[3] !== 1'b1 || out[0] !== 1'b1) begin
            errors++;
            $display("FAIL sync_vs_done got done3=%b out3=%b busy3=%b out0=%b expected 0 1 1 1",
                     done[3], out[3], busy[3], out[0]);
        end
        for (int k = 1; k < 10; k++) begin
            tick();
            checks++;
            if (out[3] !== ((k % 5) < 2) || done[3] !== 1'b0 || out[0] !== out[3]) begin
                errors++;
                $display("FAIL sync_rerun k=%0d got out3=%b out0=%b done=%b expected %b %b 0",
                         k, out[3], out[0], done[3], ((k % 5) < 2), ((k % 5) < 2));
            end
        end
        tick();
        checks++;
        if (done[3] !== 1'b1 || out[3] !== 1'b0 || busy[3] !== 1'b0) begin
            errors++;
            $display("FAIL sync_burst_end got done=%b out=%b busy=%b expected 1 0 0", done[3], out[3], busy[3]);
        end
    endtask

    task automatic test_reset_mid;
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({out, busy, done} !== 12'h000) begin
            errors++;
            $display("FAIL rst_mid got out=%b busy=%b done=%b expected all 0", out, busy, done);
        end
        rst    = 1'b0;
        enable = 4'hF;
        tick();
        tick();
        tick();
        checks++;
        if (busy !== 4'b0000 || out !== 4'b0000) begin
            errors++;
            $display("FAIL rst_cfg_cleared got busy=%b out=%b expected 0000 0000", busy, out);
        end
    endtask

    initial begin
        rst        = 1'b1;
        cfg_we     = 1'b0;
        cfg_ch     = '0;
        cfg_period = '0;
        cfg_high   = '0;
        cfg_burst  = '0;
        enable     = '0;
        sync       = 1'b0;
        test_reset();
        test_continuous();
        test_reconfig();
        test_burst();
        test_edges();
        test_sync();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
